ifetch_queue: RTL and testbench
===============================

Name: ifetch_queue

Overview:
- Instruction-fetch stage directly upstream of the instruction memory/cache.
- Owns the fetch PC and drives the memory address.
- Captures each returned instruction with its PC into a small FIFO and hands {pc, inst} pairs to decode over a valid/ready handshake.
- Decouples decode stalls and memory/cache wait cycles; supports a branch/jump redirect that flushes queued instructions.

Parameters:
- DEPTH, 4, number of FIFO entries; power of two, >= 2.
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 0.

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- imem_addr_o  output  32  fetch byte address to instruction memory/cache.
- imem_inst_i  input  32  instruction word returned for imem_addr_o, same cycle (combinational memory).
- imem_valid_i  input  1  imem_inst_i is valid this cycle; 0 means cache miss/wait.
- redirect_i  input  1  flush the queue and restart fetch (taken branch/jump).
- redirect_pc_i  input  32  new fetch address when redirect_i=1.
- inst_o  output  32  instruction at queue head.
- pc_o  output  32  PC of the instruction at queue head.
- valid_o  output  1  head entry valid for decode.
- ready_i  input  1  decode accepts the head entry.
- count_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (async, rst_ni=0):
  - fetch_pc=RESET_PC, count=0, rd_ptr=wr_ptr=0.
  - valid_o=0, inst_o=0, pc_o=0, count_o=0, imem_addr_o=RESET_PC.
  - Storage contents need not be cleared.
- imem_addr_o = fetch_pc (registered, no combinational path from inputs).
- pop = valid_o & ready_i.
- push = imem_valid_i & ~redirect_i & ((count < DEPTH) | pop). A full queue accepts a push in the same cycle as a pop.
- On push:
  - entry[wr_ptr] <= {fetch_pc, imem_inst_i}; wr_ptr++ (mod DEPTH).
  - fetch_pc <= fetch_pc + 4; wraps 32'hFFFF_FFFC -> 0.
- No push (full without pop, or imem_valid_i=0): fetch_pc holds and the same address is re-presented next cycle.
- On pop: rd_ptr++ (mod DEPTH).
- count next = count + push - pop. Simultaneous push and pop leaves count unchanged.
- valid_o = (count != 0) & ~redirect_i.
- inst_o/pc_o = head entry when count != 0, else 0.
- Latency: an instruction accepted from memory in cycle N appears at valid_o in cycle N+1 at the earliest. There is no empty-queue bypass.
- Redirect (redirect_i=1), which has priority over everything:
  - count <= 0, rd_ptr <= wr_ptr <= 0.
  - fetch_pc <= {redirect_pc_i[31:2], 2'b00}; low bits are forced to zero.
  - No push and no pop occur; valid_o is 0 that cycle, so decode cannot consume a stale entry.
  - The new target appears on imem_addr_o in cycle N+1.
- Back-to-back redirects: each one restarts from its own target; the last one wins.
- Ordering: decode receives entries in strictly increasing PC order (+4 each) between redirects. No duplicates, no drops.
- ready_i may be asserted while valid_o=0; this has no effect.
- Reset asserted mid-operation: state returns to reset values immediately. The first fetch after release is at RESET_PC.
- Invariants: 0 <= count <= DEPTH; count_o equals the number of queued entries.

Test Plan:
- Reset then stream: RESET_PC=0, imem_valid_i=1, ready_i=1, memory returns word index as data. Required:
  - imem_addr_o=0,4,8,...
  - valid_o first high at cycle 1 with pc_o=0, inst_o=0; pc_o=4 next cycle.
  - Throughput one per cycle; count_o steady at 1.
- Fill/stall: ready_i=0, imem_valid_i=1. Required:
  - count_o goes 1,2,3,4, then holds at 4.
  - imem_addr_o holds at 16 while full.
  - Raising ready_i for one cycle pops pc 0, pushes pc 16, and count_o stays 4.
- Memory wait: imem_valid_i low for 3 cycles at addr 8. Required:
  - imem_addr_o holds 8.
  - No entries pushed; decode sees pc 4 then pc 8 with no gap and no duplicate.
- Redirect with 3 queued entries, redirect_pc_i=32'h0000_0103. Required:
  - valid_o=0 in the redirect cycle; count_o=0 next cycle.
  - imem_addr_o=32'h100; next valid_o shows pc_o=32'h100.
- Simultaneous redirect and pop/push on a full queue. Required:
  - No entry is consumed; queue is empty afterwards and fetch restarts at the target.
- Wrap and async reset: redirect to 32'hFFFF_FFF8 and stream. Required:
  - pc_o sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - Pulsing rst_ni low mid-cycle clears valid_o immediately, without waiting for a clock edge.
  - After release, imem_addr_o returns to RESET_PC.

Source files
------------

// File: rtl/ifetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, captures {pc, inst} pairs from a
// combinational instruction memory into a small FIFO and feeds decode over valid/ready.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    output logic [31:0]                imem_addr_o,
    input  logic [31:0]                imem_inst_i,
    input  logic                       imem_valid_i,
    input  logic                       redirect_i,
    input  logic [31:0]                redirect_pc_i,
    output logic [31:0]                inst_o,
    output logic [31:0]                pc_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_mem_pc   [DEPTH];
    logic [31:0]   r_mem_inst [DEPTH];

    logic w_nonempty;
    logic w_pop;
    logic w_push;

    assign w_nonempty = (r_count != '0);
    // Redirect masks valid so decode can never consume an entry being flushed.
    assign valid_o    = w_nonempty & ~redirect_i;
    assign w_pop      = valid_o & ready_i;
    assign w_push     = imem_valid_i & ~redirect_i & ((r_count < CW'(DEPTH)) | w_pop);

    assign imem_addr_o = r_fetch_pc;
    assign count_o     = r_count;
    assign inst_o      = w_nonempty ? r_mem_inst[r_rd_ptr] : 32'h0;
    assign pc_o        = w_nonempty ? r_mem_pc[r_rd_ptr]   : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else if (redirect_i) begin
            r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            if (w_push) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_wr_ptr   <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage is not reset; count gates visibility of stale contents.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]   <= r_fetch_pc;
            r_mem_inst[r_wr_ptr] <= imem_inst_i;
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: memory returns the word index of each fetch address.
module tb_ifetch_queue;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_inst_i;
    logic        imem_valid_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        valid_o;
    logic        ready_i;
    logic [2:0]  count_o;

    int total = 0;
    int bad   = 0;

    ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .imem_addr_o(imem_addr_o),
        .imem_inst_i(imem_inst_i), .imem_valid_i(imem_valid_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .inst_o(inst_o), .pc_o(pc_o), .valid_o(valid_o),
        .ready_i(ready_i), .count_o(count_o)
    );

    always #5 clk_i = ~clk_i;

    assign imem_inst_i = imem_addr_o >> 2;

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; imem_valid_i = 1'b0; ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; imem_valid_i = 1'b0; ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
        total++; if (count_o !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        total++; if (imem_addr_o !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr_o); end
        total++; if (pc_o !== 32'h0 || inst_o !== 32'h0) begin bad++; $display("FAIL reset_head got=%h/%h exp=0/0", pc_o, inst_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_stream();
        do_reset();
        imem_valid_i = 1'b1; ready_i = 1'b1;
        #1;
        total++; if (imem_addr_o !== 32'h0 || valid_o !== 1'b0) begin bad++; $display("FAIL stream_c0 got=%h/%b exp=0/0", imem_addr_o, valid_o); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk_i); #1;
            total++;
            if (valid_o !== 1'b1 || pc_o !== 32'(4*(k-1)) || inst_o !== 32'(k-1)
                || imem_addr_o !== 32'(4*k) || count_o !== 3'd1) begin
                bad++;
                $display("FAIL stream_c%0d got v=%b pc=%h inst=%h addr=%h cnt=%0d exp v=1 pc=%h inst=%h addr=%h cnt=1",
                         k, valid_o, pc_o, inst_o, imem_addr_o, count_o, 4*(k-1), k-1, 4*k);
            end
        end
    endtask

    task automatic test_fill();
        do_reset();
        imem_valid_i = 1'b1; ready_i = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            #1;
            total++;
            if (count_o !== 3'((c < 4) ? c : 4) || imem_addr_o !== 32'(((c < 4) ? c : 4) * 4)) begin
                bad++;
                $display("FAIL fill_c%0d got cnt=%0d addr=%h exp cnt=%0d addr=%h",
                         c, count_o, imem_addr_o, (c < 4) ? c : 4, ((c < 4) ? c : 4) * 4);
            end
            @(negedge clk_i);
        end
        ready_i = 1'b1;
        #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || count_o !== 3'd4) begin bad++; $display("FAIL fill_pop got v=%b pc=%h cnt=%0d exp 1/0/4", valid_o, pc_o, count_o); end
        @(negedge clk_i);
        ready_i = 1'b0;
        #1;
        total++; if (count_o !== 3'd4 || pc_o !== 32'h4 || imem_addr_o !== 32'h14) begin bad++; $display("FAIL fill_after got cnt=%0d pc=%h addr=%h exp 4/4/14", count_o, pc_o, imem_addr_o); end
    endtask

    task automatic test_memwait();
        logic [31:0] exp_addr [8];
        logic [31:0] popped [$];
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC, 32'h10};
        do_reset();
        ready_i = 1'b1;
        for (int c = 0; c < 8; c++) begin
            imem_valid_i = (c < 2) || (c > 4);
            #1;
            total++; if (imem_addr_o !== exp_addr[c]) begin bad++; $display("FAIL memwait_addr_c%0d got=%h exp=%h", c, imem_addr_o, exp_addr[c]); end
            if (c == 3 || c == 4) begin
                total++; if (count_o !== 3'd0) begin bad++; $display("FAIL memwait_cnt_c%0d got=%0d exp=0", c, count_o); end
            end
            if (valid_o && ready_i) popped.push_back(pc_o);
            @(negedge clk_i);
        end
        total++;
        if (popped.size() != 4) begin
            bad++; $display("FAIL memwait_npop got=%0d exp=4", popped.size());
        end else begin
            for (int i = 0; i < 4; i++)
                if (popped[i] !== 32'(4*i)) begin bad++; $display("FAIL memwait_seq%0d got=%h exp=%h", i, popped[i], 4*i); end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_valid_i = 1'b1; ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; ready_i = 1'b1;
        #1;
        total++; if (valid_o !== 1'b0 || count_o !== 3'd3) begin bad++; $display("FAIL redir_cycle got v=%b cnt=%0d exp 0/3", valid_o, count_o); end
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        total++; if (count_o !== 3'd0 || valid_o !== 1'b0 || imem_addr_o !== 32'h100) begin bad++; $display("FAIL redir_next got cnt=%0d v=%b addr=%h exp 0/0/100", count_o, valid_o, imem_addr_o); end
        @(negedge clk_i); #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h100 || inst_o !== 32'h40) begin bad++; $display("FAIL redir_head got v=%b pc=%h inst=%h exp 1/100/40", valid_o, pc_o, inst_o); end
    endtask

    task automatic test_redirect_full();
        do_reset();
        imem_valid_i = 1'b1; ready_i = 1'b0;
        repeat (4) @(negedge clk_i);
        redirect_i = 1'b1; redirect_pc_i = 32'h200; ready_i = 1'b1;
        #1;
        total++; if (valid_o !== 1'b0 || count_o !== 3'd4) begin bad++; $display("FAIL rfull_cycle got v=%b cnt=%0d exp 0/4", valid_o, count_o); end
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        total++; if (count_o !== 3'd0 || valid_o !== 1'b0 || imem_addr_o !== 32'h200) begin bad++; $display("FAIL rfull_next got cnt=%0d v=%b addr=%h exp 0/0/200", count_o, valid_o, imem_addr_o); end
        @(negedge clk_i); #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h200 || count_o !== 3'd1) begin bad++; $display("FAIL rfull_head got v=%b pc=%h cnt=%0d exp 1/200/1", valid_o, pc_o, count_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        imem_valid_i = 1'b1; ready_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'h400;
        @(negedge clk_i);
        redirect_pc_i = 32'h802;
        #1;
        total++; if (imem_addr_o !== 32'h400 || valid_o !== 1'b0) begin bad++; $display("FAIL b2b_first got addr=%h v=%b exp 400/0", imem_addr_o, valid_o); end
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        total++; if (imem_addr_o !== 32'h800 || count_o !== 3'd0) begin bad++; $display("FAIL b2b_second got addr=%h cnt=%0d exp 800/0", imem_addr_o, count_o); end
        @(negedge clk_i); #1;
        total++; if (valid_o !== 1'b1 || pc_o !== 32'h800) begin bad++; $display("FAIL b2b_head got v=%b pc=%h exp 1/800", valid_o, pc_o); end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] exp_pc [3];
        exp_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        do_reset();
        imem_valid_i = 1'b1; ready_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        total++; if (imem_addr_o !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffff8", imem_addr_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i); #1;
            total++;
            if (valid_o !== 1'b1 || pc_o !== exp_pc[i] || inst_o !== (exp_pc[i] >> 2)) begin
                bad++; $display("FAIL wrap_pc%0d got v=%b pc=%h inst=%h exp pc=%h", i, valid_o, pc_o, inst_o, exp_pc[i]);
            end
        end
        @(negedge clk_i); #1;
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL wrap_prerst got v=%b exp=1", valid_o); end
        #2 rst_ni = 1'b0;
        #1;
        total++; if (valid_o !== 1'b0 || count_o !== 3'd0 || imem_addr_o !== 32'h0) begin bad++; $display("FAIL async_rst got v=%b cnt=%0d addr=%h exp 0/0/0", valid_o, count_o, imem_addr_o); end
        @(negedge clk_i);
        imem_valid_i = 1'b0;
        rst_ni = 1'b1;
        @(negedge clk_i); #1;
        total++; if (imem_addr_o !== 32'h0 || valid_o !== 1'b0) begin bad++; $display("FAIL post_rst got addr=%h v=%b exp 0/0", imem_addr_o, valid_o); end
    endtask

    initial begin
        rst_ni = 1'b0; imem_valid_i = 1'b0; ready_i = 1'b0;
        redirect_i = 1'b0; redirect_pc_i = 32'h0;
        test_reset();
        test_stream();
        test_fill();
        test_memwait();
        test_redirect();
        test_redirect_full();
        test_back_to_back();
        test_wrap_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
